// File: rtl/xintf_pkg.sv
// rtl/xintf_pkg.sv - shared FSM state type and bus width defaults for the XINTF front end
package xintf_pkg;

    localparam int XINTF_ADDR_W = 15;
    localparam int XINTF_DATA_W = 16;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SELECT = 3'd1,
        ST_WRITE  = 3'd2,
        ST_READ   = 3'd3,
        ST_DONE   = 3'd4
    } xintf_state_t;

endpackage

// File: rtl/xintf_sync.sv
// rtl/xintf_sync.sv - N-stage flop chain, used as strobe synchronizer and as matching delay line
module xintf_sync #(
    parameter int   STAGES  = 2,
    parameter int   WIDTH   = 1,
    parameter logic RST_BIT = 1'b1
) (
    input  logic             i_clk,
    input  logic             i_nrst,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [STAGES-1:0][WIDTH-1:0] r_chain;

    always_ff @(posedge i_clk) begin
        if (!i_nrst) begin
            r_chain <= {STAGES{{WIDTH{RST_BIT}}}};
        end else begin
            r_chain <= {r_chain[STAGES-2:0], i_d};
        end
    end

    assign o_q = r_chain[STAGES-1];

endmodule

// File: rtl/xintf_sync_frontend.sv
// rtl/xintf_sync_frontend.sv - DSP XINTF to single-clock strobe bridge; optional watchdog via XINTF_TIMEOUT_EN
module xintf_sync_frontend
    import xintf_pkg::*;
#(
    parameter int ADDR_W      = XINTF_ADDR_W,
    parameter int DATA_W      = XINTF_DATA_W,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT_CYC = 32
) (
    input  logic              clk,
    input  logic              nRST,
    input  logic [ADDR_W-1:0] address,
    input  logic              nCS,
    input  logic              nWR,
    input  logic              nRD,
    inout  wire  [DATA_W-1:0] data,
    output logic              wr_stb,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              rd_stb,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic              busy,
    output logic              err_stb
);

    localparam int STG = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

    logic              w_ncs, w_nwr, w_nrd;
    logic [ADDR_W-1:0] w_addr_al;
    logic [DATA_W-1:0] w_data_al;
    logic              w_tmo;
    logic              w_drive;

    xintf_state_t      r_state;
    logic              r_wr_stb, r_rd_stb, r_err_stb, r_busy;
    logic [ADDR_W-1:0] r_wr_addr, r_rd_addr, r_cap_addr;
    logic [DATA_W-1:0] r_wr_data, r_cap_data, r_rd_data;
    logic              r_rd_valid;
    logic [STG-1:0]    r_flush;
    logic              r_armed;

    xintf_sync #(.STAGES(STG), .WIDTH(1), .RST_BIT(1'b1)) u_sync_ncs (
        .i_clk(clk), .i_nrst(nRST), .i_d(nCS), .o_q(w_ncs));
    xintf_sync #(.STAGES(STG), .WIDTH(1), .RST_BIT(1'b1)) u_sync_nwr (
        .i_clk(clk), .i_nrst(nRST), .i_d(nWR), .o_q(w_nwr));
    xintf_sync #(.STAGES(STG), .WIDTH(1), .RST_BIT(1'b1)) u_sync_nrd (
        .i_clk(clk), .i_nrst(nRST), .i_d(nRD), .o_q(w_nrd));
    xintf_sync #(.STAGES(STG), .WIDTH(ADDR_W), .RST_BIT(1'b0)) u_dly_addr (
        .i_clk(clk), .i_nrst(nRST), .i_d(address), .o_q(w_addr_al));
    xintf_sync #(.STAGES(STG), .WIDTH(DATA_W), .RST_BIT(1'b0)) u_dly_data (
        .i_clk(clk), .i_nrst(nRST), .i_d(data), .o_q(w_data_al));

`ifdef XINTF_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
    logic [TMO_W-1:0] r_tmo_cnt;

    always_ff @(posedge clk) begin
        if (!nRST || (r_state != ST_WRITE && r_state != ST_READ)) begin
            r_tmo_cnt <= '0;
        end else begin
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
        end
    end

    assign w_tmo = (r_tmo_cnt == TMO_W'(TIMEOUT_CYC - 1));
`else
    assign w_tmo = 1'b0;
`endif

    // The chains reset to 1, so a chip select held low through reset must be
    // seen high at the flushed synchronizer output before a new cycle is accepted.
    always_ff @(posedge clk) begin
        if (!nRST) begin
            r_flush <= '0;
            r_armed <= 1'b0;
        end else begin
            r_flush <= {r_flush[STG-2:0], 1'b1};
            if (r_flush[STG-1] && w_ncs) begin
                r_armed <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!nRST) begin
            r_state    <= ST_IDLE;
            r_wr_stb   <= 1'b0;
            r_rd_stb   <= 1'b0;
            r_err_stb  <= 1'b0;
            r_busy     <= 1'b0;
            r_wr_addr  <= '0;
            r_wr_data  <= '0;
            r_rd_addr  <= '0;
            r_cap_addr <= '0;
            r_cap_data <= '0;
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            r_wr_stb  <= 1'b0;
            r_rd_stb  <= 1'b0;
            r_err_stb <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (!w_ncs && r_armed) begin
                        r_state <= ST_SELECT;
                        r_busy  <= 1'b1;
                    end
                end
                ST_SELECT: begin
                    if (w_ncs) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end else if (!w_nwr && !w_nrd) begin
                        r_err_stb <= 1'b1;
                        r_state   <= ST_DONE;
                    end else if (!w_nwr) begin
                        r_cap_addr <= w_addr_al;
                        r_cap_data <= w_data_al;
                        r_state    <= ST_WRITE;
                    end else if (!w_nrd) begin
                        r_rd_stb  <= 1'b1;
                        r_rd_addr <= w_addr_al;
                        r_state   <= ST_READ;
                    end
                end
                ST_WRITE: begin
                    if (w_ncs) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end else if (!w_nrd || w_tmo) begin
                        r_err_stb <= 1'b1;
                        r_state   <= ST_DONE;
                    end else if (w_nwr) begin
                        r_wr_stb  <= 1'b1;
                        r_wr_addr <= r_cap_addr;
                        r_wr_data <= r_cap_data;
                        r_state   <= ST_DONE;
                    end else begin
                        r_cap_addr <= w_addr_al;
                        r_cap_data <= w_data_al;
                    end
                end
                ST_READ: begin
                    if (r_rd_stb) begin
                        r_rd_data  <= rd_data;
                        r_rd_valid <= 1'b1;
                    end
                    if (w_ncs) begin
                        r_state    <= ST_IDLE;
                        r_busy     <= 1'b0;
                        r_rd_valid <= 1'b0;
                    end else if (!w_nwr || w_tmo) begin
                        r_err_stb  <= 1'b1;
                        r_state    <= ST_DONE;
                        r_rd_valid <= 1'b0;
                    end else if (w_nrd) begin
                        r_state    <= ST_DONE;
                        r_rd_valid <= 1'b0;
                    end
                end
                ST_DONE: begin
                    if (w_ncs) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // Raw strobes gate the bus so the DSP sees it released without sync delay.
    assign w_drive = r_rd_valid && !nCS && !nRD;
    assign data    = w_drive ? r_rd_data : {DATA_W{1'bz}};

    assign wr_stb  = r_wr_stb;
    assign wr_addr = r_wr_addr;
    assign wr_data = r_wr_data;
    assign rd_stb  = r_rd_stb;
    assign rd_addr = r_rd_addr;
    assign busy    = r_busy;
    assign err_stb = r_err_stb;

endmodule

// File: tb/tb_xintf_sync_frontend.sv
// tb/tb_xintf_sync_frontend.sv - directed and randomized self-checking bench for xintf_sync_frontend
module tb_xintf_sync_frontend;

    logic        clk = 1'b0;
    logic        nRST;
    logic [14:0] address;
    logic        nCS, nWR, nRD;
    wire  [15:0] data;
    logic [15:0] tb_data;
    logic        tb_den;
    logic        wr_stb, rd_stb, busy, err_stb;
    logic [14:0] wr_addr, rd_addr;
    logic [15:0] wr_data;
    logic [15:0] rd_data = 16'h0000;

    int n_checks = 0;
    int n_fail   = 0;
    int cnt_wr = 0, cnt_rd = 0, cnt_err = 0;
    int exp_wr_total = 0, exp_rd_total = 0, exp_err_total = 0;
    int base_wr, base_rd, base_err, first_err;
    logic [31:0] exp_wq[$];
    logic [14:0] exp_rq[$];
    logic [31:0] mon_e;
    logic [14:0] mon_a;

    assign data = tb_den ? tb_data : 16'hzzzz;

    always #5 clk = ~clk;

    xintf_sync_frontend dut (
        .clk(clk), .nRST(nRST), .address(address),
        .nCS(nCS), .nWR(nWR), .nRD(nRD), .data(data),
        .wr_stb(wr_stb), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_stb(rd_stb), .rd_addr(rd_addr), .rd_data(rd_data),
        .busy(busy), .err_stb(err_stb)
    );

    function automatic logic [15:0] rd_model(input logic [14:0] a);
        return {1'b0, a} ^ 16'hA5A0;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every committed write/read must match the oldest outstanding host transaction.
    always @(negedge clk) begin
        if (wr_stb === 1'b1) begin
            cnt_wr++;
            check("wr_pending", 32'(exp_wq.size() != 0), 32'd1);
            if (exp_wq.size() != 0) begin
                mon_e = exp_wq.pop_front();
                check("wr_addr", 32'(wr_addr), 32'(mon_e[30:16]));
                check("wr_data", 32'(wr_data), 32'(mon_e[15:0]));
            end
        end
        if (rd_stb === 1'b1) begin
            cnt_rd++;
            check("rd_pending", 32'(exp_rq.size() != 0), 32'd1);
            if (exp_rq.size() != 0) begin
                mon_a = exp_rq.pop_front();
                check("rd_addr", 32'(rd_addr), 32'(mon_a));
            end
            rd_data = rd_model(rd_addr);
        end
        if (err_stb === 1'b1) cnt_err++;
    end

    task automatic do_write(input logic [14:0] a, input logic [15:0] d,
                            input int lead, input int wlen, input int tail, input int gap);
        @(negedge clk);
        address = a; tb_data = d; tb_den = 1'b1; nCS = 1'b0;
        repeat (lead) @(negedge clk);
        nWR = 1'b0;
        repeat (wlen) @(negedge clk);
        nWR = 1'b1;
        address = 15'($urandom); tb_data = 16'($urandom);
        exp_wq.push_back({1'b0, a, d});
        exp_wr_total++;
        repeat (tail) @(negedge clk);
        nCS = 1'b1;
        repeat (gap) @(negedge clk);
    endtask

    task automatic do_read(input logic [14:0] a, input int lead, input int rlen,
                           input int tail, input int gap);
        @(negedge clk);
        address = a; tb_den = 1'b0; nCS = 1'b0;
        repeat (lead) @(negedge clk);
        nRD = 1'b0;
        exp_rq.push_back(a);
        exp_rd_total++;
        repeat (rlen) @(negedge clk);
        check("rd_bus_driven", 32'(data), 32'(rd_model(a)));
        nRD = 1'b1; tb_data = 16'h0000; tb_den = 1'b1;
        #1 check("rd_bus_released", 32'(data), 32'h0);
        address = 15'($urandom);
        repeat (tail) @(negedge clk);
        nCS = 1'b1;
        repeat (gap) @(negedge clk);
    endtask

    initial begin
        nRST = 1'b0; nCS = 1'b1; nWR = 1'b1; nRD = 1'b1;
        address = '0; tb_data = 16'h0000; tb_den = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_wr_stb", 32'(wr_stb), 32'd0);
        check("rst_rd_stb", 32'(rd_stb), 32'd0);
        check("rst_err_stb", 32'(err_stb), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_wr_addr", 32'(wr_addr), 32'd0);
        check("rst_wr_data", 32'(wr_data), 32'd0);
        check("rst_bus_released", 32'(data), 32'd0);
        nRST = 1'b1;
        repeat (4) @(negedge clk);

        // Single write, latency from raw nWR rise
        @(negedge clk);
        address = 15'h3FFA; tb_data = 16'h0001; tb_den = 1'b1; nCS = 1'b0;
        repeat (2) @(negedge clk);
        nWR = 1'b0;
        repeat (5) @(negedge clk);
        nWR = 1'b1;
        exp_wq.push_back({1'b0, 15'h3FFA, 16'h0001});
        exp_wr_total++;
        base_wr = cnt_wr;
        @(negedge clk); check("w_lat1", 32'(wr_stb), 32'd0);
        @(negedge clk); check("w_lat2", 32'(wr_stb), 32'd0);
        @(negedge clk); check("w_lat3", 32'(wr_stb), 32'd1);
        nCS = 1'b1;
        @(negedge clk); check("w_lat4", 32'(wr_stb), 32'd0);
        repeat (4) @(negedge clk);
        check("w_count", 32'(cnt_wr - base_wr), 32'd1);
        check("w_hold_addr", 32'(wr_addr), 32'h3FFA);
        check("w_hold_data", 32'(wr_data), 32'h0001);
        check("w_idle_busy", 32'(busy), 32'd0);

        // Chip select dropped while nWR still low
        base_wr = cnt_wr;
        @(negedge clk);
        address = 15'h1234; tb_data = 16'hBEEF; nCS = 1'b0;
        repeat (2) @(negedge clk);
        nWR = 1'b0;
        repeat (4) @(negedge clk);
        nCS = 1'b1;
        repeat (4) @(negedge clk);
        nWR = 1'b1;
        repeat (4) @(negedge clk);
        check("abort_no_wr", 32'(cnt_wr - base_wr), 32'd0);
        check("abort_wr_addr", 32'(wr_addr), 32'h3FFA);
        check("abort_busy", 32'(busy), 32'd0);

        // nWR and nRD together
        base_wr = cnt_wr; base_rd = cnt_rd; base_err = cnt_err;
        @(negedge clk);
        tb_den = 1'b0; nCS = 1'b0;
        repeat (2) @(negedge clk);
        nWR = 1'b0; nRD = 1'b0;
        repeat (3) @(negedge clk);
        nWR = 1'b1; nRD = 1'b1;
        exp_err_total++;
        repeat (3) @(negedge clk);
        check("both_busy_held", 32'(busy), 32'd1);
        nCS = 1'b1;
        repeat (5) @(negedge clk);
        check("both_busy_drop", 32'(busy), 32'd0);
        check("both_err", 32'(cnt_err - base_err), 32'd1);
        check("both_no_wr", 32'(cnt_wr - base_wr), 32'd0);
        check("both_no_rd", 32'(cnt_rd - base_rd), 32'd0);

        // Sub-cycle nWR glitch between rising edges
        base_wr = cnt_wr; base_err = cnt_err;
        @(negedge clk);
        tb_den = 1'b1; nCS = 1'b0;
        repeat (3) @(negedge clk);
        #1 nWR = 1'b0;
        #2 nWR = 1'b1;
        repeat (4) @(negedge clk);
        nCS = 1'b1;
        repeat (4) @(negedge clk);
        check("glitch_no_wr", 32'(cnt_wr - base_wr), 32'd0);
        check("glitch_no_err", 32'(cnt_err - base_err), 32'd0);

        // Directed read of address 5
        base_rd = cnt_rd;
        do_read(15'h0005, 2, 6, 2, 3);
        check("rd_count", 32'(cnt_rd - base_rd), 32'd1);
        check("rd_model_5", 32'(rd_data), 32'hA5A5);

        // Reset pulse mid-write, then a write-less chip select afterwards
        base_wr = cnt_wr;
        @(negedge clk);
        address = 15'h0ABC; tb_data = 16'h1111; tb_den = 1'b1; nCS = 1'b0;
        repeat (2) @(negedge clk);
        nWR = 1'b0;
        repeat (3) @(negedge clk);
        nRST = 1'b0;
        @(negedge clk);
        tb_data = 16'h0000;
        #1;
        check("mrst_wr_stb", 32'(wr_stb), 32'd0);
        check("mrst_busy", 32'(busy), 32'd0);
        check("mrst_wr_addr", 32'(wr_addr), 32'd0);
        check("mrst_wr_data", 32'(wr_data), 32'd0);
        check("mrst_bus_released", 32'(data), 32'd0);
        nRST = 1'b1;
        repeat (3) @(negedge clk);
        nWR = 1'b1;
        repeat (4) @(negedge clk);
        check("mrst_stale_busy", 32'(busy), 32'd0);
        nCS = 1'b1;
        repeat (4) @(negedge clk);
        check("mrst_no_wr", 32'(cnt_wr - base_wr), 32'd0);

        // nWR held low for 40 cycles
        base_wr = cnt_wr; base_err = cnt_err; first_err = -1;
        @(negedge clk);
        address = 15'h0777; tb_data = 16'h4242; tb_den = 1'b1; nCS = 1'b0;
        repeat (2) @(negedge clk);
        nWR = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (err_stb === 1'b1 && first_err < 0) first_err = i;
        end
        nWR = 1'b1;
`ifdef XINTF_TIMEOUT_EN
        exp_err_total++;
`else
        exp_wq.push_back({1'b0, 15'h0777, 16'h4242});
        exp_wr_total++;
`endif
        repeat (4) @(negedge clk);
        nCS = 1'b1;
        repeat (4) @(negedge clk);
`ifdef XINTF_TIMEOUT_EN
        check("tmo_err", 32'(cnt_err - base_err), 32'd1);
        check("tmo_no_wr", 32'(cnt_wr - base_wr), 32'd0);
        check("tmo_err_cycle", 32'(first_err >= 33 && first_err <= 36), 32'd1);
`else
        check("long_no_err", 32'(cnt_err - base_err), 32'd0);
        check("long_wr", 32'(cnt_wr - base_wr), 32'd1);
        check("long_first_err", 32'(first_err), 32'hFFFF_FFFF);
`endif

        // 2000 back-to-back writes with randomized strobe timing
        base_wr = cnt_wr;
        for (int i = 0; i < 2000; i++) begin
            do_write(15'h3FFA + 15'(i), 16'(i + 1), $urandom_range(1, 3),
                     $urandom_range(1, 4), $urandom_range(2, 3), $urandom_range(1, 2));
        end
        repeat (6) @(negedge clk);
        check("burst_count", 32'(cnt_wr - base_wr), 32'd2000);

        // Random mix of reads and writes
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 1) == 0) begin
                do_write(15'($urandom), 16'($urandom), $urandom_range(1, 3),
                         $urandom_range(1, 5), $urandom_range(2, 4), $urandom_range(1, 3));
            end else begin
                do_read(15'($urandom), $urandom_range(1, 3), $urandom_range(5, 8),
                        $urandom_range(1, 3), $urandom_range(1, 3));
            end
        end
        repeat (10) @(negedge clk);

        check("final_wq_empty", 32'(exp_wq.size()), 32'd0);
        check("final_rq_empty", 32'(exp_rq.size()), 32'd0);
        check("final_wr_total", 32'(cnt_wr), 32'(exp_wr_total));
        check("final_rd_total", 32'(cnt_rd), 32'(exp_rd_total));
        check("final_err_total", 32'(cnt_err), 32'(exp_err_total));
        check("final_busy", 32'(busy), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/xintf_sync_frontend.md
XINTF_SYNC_FRONTEND -- requirements
Module: xintf_sync_frontend

Interface
REQ-001 SHALL have parameter ADDR_W, default 15, DSP XINTF address width.
REQ-002 SHALL have parameter DATA_W, default 16, XINTF data width.
REQ-003 SHALL have parameter SYNC_STAGES, default 2, synchronizer depth (minimum 2).
REQ-004 SHALL have parameter TIMEOUT_CYC, default 32, strobe watchdog limit in clk cycles.
REQ-005 clk  in  1  single system clock; all logic on rising edge.
REQ-006 nRST  in  1  reset, synchronous, active-low.
REQ-007 address  in  ADDR_W  raw asynchronous DSP address.
REQ-008 nCS, nWR, nRD  in  1 each  raw asynchronous DSP strobes, active-low.
REQ-009 data  inout  DATA_W  DSP data bus; driven only per REQ-021, else high-Z.
REQ-010 wr_stb  out  1  one-cycle pulse, committed write.
REQ-011 wr_addr, wr_data  out  ADDR_W/DATA_W  write payload, valid when wr_stb=1, held until next commit.
REQ-012 rd_stb  out  1  one-cycle read request pulse.
REQ-013 rd_addr  out  ADDR_W  read address, valid when rd_stb=1.
REQ-014 rd_data  in  DATA_W  downstream read data, valid exactly 1 cycle after rd_stb.
REQ-015 busy  out  1  high when FSM not IDLE.
REQ-016 err_stb  out  1  one-cycle pulse on protocol error or timeout.

Function
REQ-017 nCS, nWR, nRD SHALL each pass a SYNC_STAGES flop chain; address and data SHALL be delayed through the same number of stages to stay aligned.
REQ-018 FSM states IDLE, SELECT, WRITE, READ, DONE: IDLE->SELECT on synced nCS=0; SELECT->WRITE on synced nWR=0; SELECT->READ on synced nRD=0; WRITE/READ->DONE on strobe release; DONE->IDLE on synced nCS=1.
REQ-019 In WRITE, aligned address/data SHALL be captured every cycle; on synced nWR 0->1 with synced nCS=0, wr_stb SHALL pulse one cycle later with last captured values (3 cycles after raw rising edge at SYNC_STAGES=2).
REQ-020 On entry to READ, rd_stb SHALL pulse once with aligned address on rd_addr; rd_data SHALL be registered in the following cycle.
REQ-021 data SHALL be driven with registered rd_data from the cycle after capture while raw nCS=0 and raw nRD=0; released combinationally when either raw strobe goes high.
REQ-022 Synced nWR=0 and nRD=0 simultaneously SHALL pulse err_stb, emit no strobes, go to DONE.
REQ-023 Synced nCS=1 while in WRITE before nWR release SHALL abort: no wr_stb, go to IDLE.
REQ-024 At most one wr_stb or rd_stb SHALL occur per nCS assertion; address changes inside a cycle are ignored after commit.
REQ-025 Strobe glitches shorter than one clk SHALL not generate strobes unless seen by synchronizer.

Reset
REQ-026 With nRST=0 at a clk edge: FSM=IDLE, wr_stb=rd_stb=err_stb=0, busy=0, wr_addr=wr_data=0, data high-Z, sync chains loaded to 1.
REQ-027 Reset mid-transaction SHALL discard it; the first transaction after release SHALL require a fresh nCS falling edge.

Configuration
REQ-028 With XINTF_TIMEOUT_EN defined, a cycle counter SHALL run in WRITE/READ; reaching TIMEOUT_CYC SHALL pulse err_stb, suppress the pending wr_stb, and go to DONE.
REQ-029 Without XINTF_TIMEOUT_EN, no counter SHALL exist; WRITE/READ wait indefinitely.

Structure
REQ-030 Package xintf_pkg SHALL hold the FSM state type and ADDR_W/DATA_W defaults.
REQ-031 Sub-module xintf_sync (parameterised N-stage synchronizer, reset value 1) SHALL be instantiated per strobe.

Verification
REQ-032 Write addr 0x3FFA data 0x0001, nCS low 10 cycles, nWR low 5 -> single wr_stb 3 cycles after nWR rise, wr_addr=0x3FFA, wr_data=0x0001.
REQ-033 2000 back-to-back writes 0x3FFA.. data 1..2000 -> 2000 wr_stb, payloads exact and in order.
REQ-034 Read addr 0x0005, rd_data model returns 0xA5A5 -> one rd_stb with rd_addr=0x0005, data=0xA5A5 before nRD rises, high-Z after.
REQ-035 nWR and nRD low together -> err_stb once, no wr_stb/rd_stb, busy drops after nCS high.
REQ-036 nCS raised while nWR low -> no wr_stb; nRST pulsed mid-write -> no wr_stb, outputs at reset values.
REQ-037 XINTF_TIMEOUT_EN, nWR held low 40 cycles -> err_stb at cycle 32, no wr_stb.
